// File: rtl/coh_pkg.sv
// Shared MESI coherence types and the snoop state-transition function.
// Used by the per-core coherence agent and its snoop unit.
package coh_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_UPGR = 2'b01,
        OP_RDX  = 2'b10,
        OP_NON  = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_BUS  = 2'b10,
        ST_FILL = 2'b11
    } agent_st_t;

    function automatic mesi_t next_snoop_state(input bus_op_t op, input mesi_t st);
        mesi_t n;
        n = st;
        case (op)
            OP_RD:   if (st == MESI_M || st == MESI_E) n = MESI_S;
            OP_RDX:  n = MESI_I;
            OP_UPGR: if (st == MESI_S) n = MESI_I;
            default: n = st;
        endcase
        return n;
    endfunction

    // A peer read or read-exclusive of a dirty line forces a write-back.
    function automatic logic snoop_flush(input bus_op_t op, input mesi_t st);
        return ((op == OP_RD) || (op == OP_RDX)) && (st == MESI_M);
    endfunction

endpackage

// File: rtl/coh_snoop_unit.sv
// Registered snoop response: state-write strobe, new state and flush request,
// all valid one cycle after the peer bus operation.
module coh_snoop_unit
    import coh_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] snoop_op_in,
    input  logic [1:0] snoop_state,
    output logic       snoop_upd,
    output logic [1:0] snoop_new_st,
    output logic       flush_req
);

    bus_op_t w_op;
    mesi_t   w_cur;
    mesi_t   w_nst;
    logic    w_chg;
    logic    r_upd;
    mesi_t   r_new_st;
    logic    r_flush;

    assign w_op  = bus_op_t'(snoop_op_in);
    assign w_cur = mesi_t'(snoop_state);
    assign w_nst = next_snoop_state(w_op, w_cur);
    assign w_chg = (w_op != OP_NON) && (w_nst != w_cur);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_upd    <= 1'b0;
            r_new_st <= MESI_I;
            r_flush  <= 1'b0;
        end else begin
            r_upd    <= w_chg;
            r_new_st <= w_chg ? w_nst : MESI_I;
            r_flush  <= snoop_flush(w_op, w_cur);
        end
    end

    assign snoop_upd    = r_upd;
    assign snoop_new_st = r_new_st;
    assign flush_req    = r_flush;

endmodule

// File: rtl/l1_coherence_agent.sv
// Per-core MESI agent: turns L1 misses/upgrades into bus requests, returns the
// fill to the L1 and answers peer snoops; stalls the core while a request is open.
module l1_coherence_agent
    import coh_pkg::*;
#(
    parameter int RESP_LAT = 1,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_valid,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic          l1_hit,
    input  logic [1:0]    l1_state,
    output logic          stall_core,
    output logic          req_core,
    input  logic          grant,
    output logic [1:0]    bus_op_out,
    output logic [AW-1:0] bus_addr_out,
    input  logic [DW-1:0] bus_data_in,
    input  logic          peer_hit_in,
    output logic          fill_valid,
    output logic [DW-1:0] fill_data,
    output logic [1:0]    fill_state,
    input  logic [1:0]    snoop_op_in,
    input  logic [AW-1:0] snoop_addr_in,
    input  logic [1:0]    snoop_state,
    output logic          snoop_upd,
    output logic [1:0]    snoop_new_st,
    output logic          supply_hit,
    output logic          flush_req
);

    localparam int CW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

    agent_st_t     r_state, w_state_nxt;
    bus_op_t       r_op, w_op_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0] r_data, w_data_nxt;
    logic          r_peer, w_peer_nxt;
    logic          r_efill, w_efill_nxt;

    bus_op_t       w_dec_op;
    logic          w_dec_efill;
    logic          w_line_vld;
    logic          w_snoop_kill;

    assign w_line_vld = l1_hit && (mesi_t'(l1_state) != MESI_I);

    always_comb begin
        w_dec_op    = OP_NON;
        w_dec_efill = 1'b0;
        if (cpu_valid && !reset) begin
            if (!w_line_vld)
                w_dec_op = cpu_we ? OP_RDX : OP_RD;
            else if (cpu_we && mesi_t'(l1_state) == MESI_S)
                w_dec_op = OP_UPGR;
            else if (cpu_we && mesi_t'(l1_state) == MESI_E)
                w_dec_efill = 1'b1;
        end
    end

    // Peer invalidates our shared copy before we own the bus: the upgrade
    // must turn into a full read-exclusive since our data is now stale.
    assign w_snoop_kill = (bus_op_t'(snoop_op_in) != OP_NON) &&
                          (snoop_addr_in == r_addr) &&
                          (mesi_t'(snoop_state) != MESI_I) &&
                          (next_snoop_state(bus_op_t'(snoop_op_in),
                                            mesi_t'(snoop_state)) == MESI_I);

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_addr_nxt   = r_addr;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_data;
        w_peer_nxt   = r_peer;
        w_efill_nxt  = 1'b0;
        stall_core   = 1'b0;
        req_core     = 1'b0;
        bus_op_out   = OP_NON;
        bus_addr_out = '0;
        case (r_state)
            ST_IDLE: begin
                w_efill_nxt = w_dec_efill;
                if (w_dec_op != OP_NON) begin
                    w_state_nxt = ST_REQ;
                    w_op_nxt    = w_dec_op;
                    w_addr_nxt  = cpu_addr;
                    stall_core  = 1'b1;
                end
            end
            ST_REQ: begin
                stall_core   = 1'b1;
                req_core     = 1'b1;
                bus_op_out   = r_op;
                bus_addr_out = r_addr;
                if (grant) begin
                    w_state_nxt = ST_BUS;
                    w_cnt_nxt   = '0;
                end else if (r_op == OP_UPGR && w_snoop_kill) begin
                    w_op_nxt = OP_RDX;
                end
            end
            ST_BUS: begin
                stall_core   = 1'b1;
                bus_op_out   = r_op;
                bus_addr_out = r_addr;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (r_cnt == CW'(RESP_LAT - 1)) begin
                    w_data_nxt  = bus_data_in;
                    w_peer_nxt  = peer_hit_in;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                stall_core  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NON;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_peer  <= 1'b0;
            r_efill <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_peer  <= w_peer_nxt;
            r_efill <= w_efill_nxt;
        end
    end

    always_comb begin
        fill_valid = (r_state == ST_FILL) || r_efill;
        fill_data  = (r_state == ST_FILL) ? r_data : '0;
        fill_state = MESI_I;
        if (r_efill)
            fill_state = MESI_M;
        else if (r_state == ST_FILL)
            fill_state = (r_op == OP_RD) ? (r_peer ? MESI_S : MESI_E) : MESI_M;
    end

    assign supply_hit = !reset && (bus_op_t'(snoop_op_in) != OP_NON) &&
                        (mesi_t'(snoop_state) != MESI_I);

    coh_snoop_unit u_snoop (
        .clk          (clk),
        .reset        (reset),
        .snoop_op_in  (snoop_op_in),
        .snoop_state  (snoop_state),
        .snoop_upd    (snoop_upd),
        .snoop_new_st (snoop_new_st),
        .flush_req    (flush_req)
    );

endmodule

// File: tb/tb_l1_coherence_agent.sv
// Directed vector table for l1_coherence_agent plus a hand-written miss with
// a delayed grant.
module tb_l1_coherence_agent;

    localparam logic [1:0] I = 2'b00, S = 2'b01, E = 2'b10, M = 2'b11;
    localparam logic [1:0] RD = 2'b00, UP = 2'b01, RX = 2'b10, NN = 2'b11;

    typedef struct {
        logic        rst;
        logic        cv;
        logic        we;
        logic [31:0] addr;
        logic        hit;
        logic [1:0]  st;
        logic        gnt;
    } cpu_t;

    typedef struct {
        logic [31:0] data;
        logic        peer;
    } bus_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [1:0]  st;
    } snp_t;

    typedef struct {
        logic        stall;
        logic        req;
        logic [1:0]  op;
        logic [31:0] baddr;
        logic        fv;
        logic [1:0]  fst;
        logic        fdchk;
        logic [31:0] fdata;
        logic        supd;
        logic [1:0]  snst;
        logic        sup;
        logic        flush;
    } exp_t;

    typedef struct {
        cpu_t c;
        bus_t b;
        snp_t s;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_we, l1_hit, grant, peer_hit_in;
    logic [31:0] cpu_addr, bus_data_in, snoop_addr_in;
    logic [1:0]  l1_state, snoop_op_in, snoop_state;
    logic        stall_core, req_core, fill_valid, snoop_upd, supply_hit, flush_req;
    logic [1:0]  bus_op_out, fill_state, snoop_new_st;
    logic [31:0] bus_addr_out, fill_data;

    int n_chk  = 0;
    int n_pass = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    l1_coherence_agent dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_valid     (cpu_valid),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .l1_hit        (l1_hit),
        .l1_state      (l1_state),
        .stall_core    (stall_core),
        .req_core      (req_core),
        .grant         (grant),
        .bus_op_out    (bus_op_out),
        .bus_addr_out  (bus_addr_out),
        .bus_data_in   (bus_data_in),
        .peer_hit_in   (peer_hit_in),
        .fill_valid    (fill_valid),
        .fill_data     (fill_data),
        .fill_state    (fill_state),
        .snoop_op_in   (snoop_op_in),
        .snoop_addr_in (snoop_addr_in),
        .snoop_state   (snoop_state),
        .snoop_upd     (snoop_upd),
        .snoop_new_st  (snoop_new_st),
        .supply_hit    (supply_hit),
        .flush_req     (flush_req)
    );

    function automatic cpu_t ci(input logic rst, cv, we, input logic [31:0] a,
                                input logic hit, input logic [1:0] st, input logic gnt);
        cpu_t r;
        r.rst = rst; r.cv = cv; r.we = we; r.addr = a; r.hit = hit; r.st = st; r.gnt = gnt;
        return r;
    endfunction

    function automatic bus_t bi(input logic [31:0] d, input logic p);
        bus_t r;
        r.data = d; r.peer = p;
        return r;
    endfunction

    function automatic snp_t si(input logic [1:0] op, input logic [31:0] a, input logic [1:0] st);
        snp_t r;
        r.op = op; r.addr = a; r.st = st;
        return r;
    endfunction

    function automatic exp_t ex(input logic stall, req, input logic [1:0] op,
                                input logic [31:0] baddr, input logic fv,
                                input logic [1:0] fst, input logic fdchk,
                                input logic [31:0] fdata, input logic supd,
                                input logic [1:0] snst, input logic sup, flush);
        exp_t r;
        r.stall = stall; r.req = req; r.op = op; r.baddr = baddr; r.fv = fv;
        r.fst = fst; r.fdchk = fdchk; r.fdata = fdata; r.supd = supd;
        r.snst = snst; r.sup = sup; r.flush = flush;
        return r;
    endfunction

    task automatic add(input cpu_t c, input bus_t b, input snp_t s, input exp_t e);
        vec_t v;
        v.c = c; v.b = b; v.s = s; v.e = e;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        reset         = v.c.rst;
        cpu_valid     = v.c.cv;
        cpu_we        = v.c.we;
        cpu_addr      = v.c.addr;
        l1_hit        = v.c.hit;
        l1_state      = v.c.st;
        grant         = v.c.gnt;
        bus_data_in   = v.b.data;
        peer_hit_in   = v.b.peer;
        snoop_op_in   = v.s.op;
        snoop_addr_in = v.s.addr;
        snoop_state   = v.s.st;
    endtask

    initial begin
        cpu_t C0;
        bus_t NB;
        snp_t NS;
        exp_t IDL;
        logic got;

        C0  = ci(0, 0, 0, 0, 0, I, 0);
        NB  = bi(0, 0);
        NS  = si(NN, 0, I);
        IDL = ex(0, 0, NN, 0, 0, I, 0, 0, 0, I, 0, 0);

        // reset state
        add(ci(1, 0, 0, 0, 0, I, 0), NB, NS, IDL);
        // load miss 0x100, grant on second REQ cycle, fill from L2 -> E
        add(ci(0, 1, 0, 'h100, 0, I, 0), NB, NS, ex(1, 0, NN, 0, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, NB, NS, ex(1, 1, RD, 'h100, 0, I, 0, 0, 0, I, 0, 0));
        add(ci(0, 0, 0, 0, 0, I, 1), NB, NS, ex(1, 1, RD, 'h100, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, bi('hDEAD, 0), NS, ex(1, 0, RD, 'h100, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, NB, NS, ex(1, 0, NN, 0, 1, E, 1, 'hDEAD, 0, I, 0, 0));
        add(C0, NB, NS, IDL);
        // load miss, peer supplies -> S
        add(ci(0, 1, 0, 'h140, 0, I, 0), NB, NS, ex(1, 0, NN, 0, 0, I, 0, 0, 0, I, 0, 0));
        add(ci(0, 0, 0, 0, 0, I, 1), NB, NS, ex(1, 1, RD, 'h140, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, bi('hBEEF, 1), NS, ex(1, 0, RD, 'h140, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, NB, NS, ex(1, 0, NN, 0, 1, S, 1, 'hBEEF, 0, I, 0, 0));
        add(C0, NB, NS, IDL);
        // store hit S -> upgrade -> M, data not checked
        add(ci(0, 1, 1, 'h180, 1, S, 0), NB, NS, ex(1, 0, NN, 0, 0, I, 0, 0, 0, I, 0, 0));
        add(ci(0, 0, 0, 0, 0, I, 1), NB, NS, ex(1, 1, UP, 'h180, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, bi('h1234, 0), NS, ex(1, 0, UP, 'h180, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, NB, NS, ex(1, 0, NN, 0, 1, M, 0, 0, 0, I, 0, 0));
        add(C0, NB, NS, IDL);
        // store hit E: silent fill to M; load hit and store hit M: nothing
        add(ci(0, 1, 1, 'h1C0, 1, E, 0), NB, NS, IDL);
        add(C0, NB, NS, ex(0, 0, NN, 0, 1, M, 0, 0, 0, I, 0, 0));
        add(ci(0, 1, 0, 'h1C0, 1, M, 0), NB, NS, IDL);
        add(ci(0, 1, 1, 'h1C0, 1, M, 0), NB, NS, IDL);
        add(C0, NB, NS, IDL);
        // snoops
        add(C0, NB, si(RX, 'h200, M), ex(0, 0, NN, 0, 0, I, 0, 0, 0, I, 1, 0));
        add(C0, NB, NS, ex(0, 0, NN, 0, 0, I, 0, 0, 1, I, 0, 1));
        add(C0, NB, si(RD, 'h204, E), ex(0, 0, NN, 0, 0, I, 0, 0, 0, I, 1, 0));
        add(C0, NB, NS, ex(0, 0, NN, 0, 0, I, 0, 0, 1, S, 0, 0));
        add(C0, NB, si(RD, 'h208, S), ex(0, 0, NN, 0, 0, I, 0, 0, 0, I, 1, 0));
        add(C0, NB, NS, IDL);
        add(C0, NB, si(UP, 'h20C, E), ex(0, 0, NN, 0, 0, I, 0, 0, 0, I, 1, 0));
        add(C0, NB, NS, IDL);
        add(C0, NB, si(RX, 'h210, I), IDL);
        add(C0, NB, NS, IDL);
        // pending upgrade killed by peer upgrade -> RDX; fill overlaps a snoop update
        add(ci(0, 1, 1, 'h300, 1, S, 0), NB, NS, ex(1, 0, NN, 0, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, NB, si(UP, 'h300, S), ex(1, 1, UP, 'h300, 0, I, 0, 0, 0, I, 1, 0));
        add(C0, NB, NS, ex(1, 1, RX, 'h300, 0, I, 0, 0, 1, I, 0, 0));
        add(ci(0, 0, 0, 0, 0, I, 1), NB, NS, ex(1, 1, RX, 'h300, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, bi('h5555, 0), si(RD, 'h400, E), ex(1, 0, RX, 'h300, 0, I, 0, 0, 0, I, 1, 0));
        add(C0, NB, NS, ex(1, 0, NN, 0, 1, M, 1, 'h5555, 1, S, 0, 0));
        add(C0, NB, NS, IDL);
        // reset while in BUS
        add(ci(0, 1, 0, 'h500, 0, I, 0), NB, NS, ex(1, 0, NN, 0, 0, I, 0, 0, 0, I, 0, 0));
        add(ci(0, 0, 0, 0, 0, I, 1), NB, NS, ex(1, 1, RD, 'h500, 0, I, 0, 0, 0, I, 0, 0));
        add(ci(1, 0, 0, 0, 0, I, 0), bi('h777, 0), NS, ex(1, 0, RD, 'h500, 0, I, 0, 0, 0, I, 0, 0));
        add(C0, NB, NS, IDL);
        add(C0, NB, NS, IDL);

        drive(tv[0]);
        repeat (2) @(posedge clk);

        for (int k = 0; k < tv.size(); k++) begin
            @(posedge clk);
            #2;
            drive(tv[k]);
            #2;
            chk($sformatf("r%0d stall_core", k), 32'(stall_core), 32'(tv[k].e.stall));
            chk($sformatf("r%0d req_core", k), 32'(req_core), 32'(tv[k].e.req));
            chk($sformatf("r%0d bus_op_out", k), 32'(bus_op_out), 32'(tv[k].e.op));
            chk($sformatf("r%0d bus_addr_out", k), bus_addr_out, tv[k].e.baddr);
            chk($sformatf("r%0d fill_valid", k), 32'(fill_valid), 32'(tv[k].e.fv));
            if (tv[k].e.fv)
                chk($sformatf("r%0d fill_state", k), 32'(fill_state), 32'(tv[k].e.fst));
            if (tv[k].e.fv && tv[k].e.fdchk)
                chk($sformatf("r%0d fill_data", k), fill_data, tv[k].e.fdata);
            chk($sformatf("r%0d snoop_upd", k), 32'(snoop_upd), 32'(tv[k].e.supd));
            if (tv[k].e.supd)
                chk($sformatf("r%0d snoop_new_st", k), 32'(snoop_new_st), 32'(tv[k].e.snst));
            chk($sformatf("r%0d supply_hit", k), 32'(supply_hit), 32'(tv[k].e.sup));
            chk($sformatf("r%0d flush_req", k), 32'(flush_req), 32'(tv[k].e.flush));
        end

        // store miss with grant withheld for three cycles
        @(posedge clk);
        #2;
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 'h600; l1_hit = 1'b0; grant = 1'b0;
        #2;
        chk("seq stall on decode", 32'(stall_core), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            cpu_valid = 1'b0;
            #2;
            chk($sformatf("seq wait%0d req_core", c), 32'(req_core), 32'd1);
            chk($sformatf("seq wait%0d bus_op_out", c), 32'(bus_op_out), 32'(RX));
        end
        @(posedge clk);
        #2;
        grant = 1'b1;
        bus_data_in = 'hCAFE;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(posedge clk);
            #2;
            grant = 1'b0;
            #2;
            if (fill_valid) got = 1'b1;
        end
        chk("seq fill seen", 32'(got), 32'd1);
        if (got) begin
            chk("seq fill_data", fill_data, 32'hCAFE);
            chk("seq fill_state", 32'(fill_state), 32'(M));
            @(posedge clk);
            #4;
            chk("seq stall drop", 32'(stall_core), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
